// File: rtl/alu_exec_if.sv
// Request/response bundle between the ID/EX register, the hazard logic and the execute-stage ALU.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             flush_i;
    logic             ready_o;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i, flush_i,
        output ready_o, busy_o, valid_o, result_o, zero_o
    );

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i, flush_i,
        input  ready_o, busy_o, valid_o, result_o, zero_o
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith ops with a registered result, plus a
// WIDTH-iteration shift-add multiplier that holds off new requests while it runs.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_exec_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, acc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;
    logic             is_mult;
    logic             last_iter;

    logic [WIDTH-1:0] result;
    logic             zero;
    logic             valid;

    assign bus.ready_o  = (state == IDLE);
    assign bus.busy_o   = (state != IDLE);
    assign bus.valid_o  = valid;
    assign bus.result_o = result;
    assign bus.zero_o   = zero;

    assign accept    = (state == IDLE) && bus.valid_i && !bus.flush_i;
    assign is_mult   = (bus.ALUCtrl_i == 4'd3);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign acc_nxt   = mplier[0] ? acc + mcand : acc;

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            4'd0: alu_res = bus.src1_i & bus.src2_i;
            4'd1: alu_res = bus.src1_i | bus.src2_i;
            4'd2: alu_res = bus.src1_i + bus.src2_i;
            4'd6: alu_res = bus.src1_i - bus.src2_i;
            4'd7: alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && is_mult) state_nxt = MUL;
            MUL:  if (bus.flush_i || last_iter) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result <= '0;
            zero   <= 1'b1;
            valid  <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    if (is_mult) begin
                        mcand  <= bus.src1_i;
                        mplier <= bus.src2_i;
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        result <= alu_res;
                        zero   <= (alu_res == '0);
                        valid  <= 1'b1;
                    end
                end
            end else if (!bus.flush_i) begin
                // Low WIDTH bits of the product are sign-agnostic, so no correction step.
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (last_iter) begin
                    result <= acc_nxt;
                    zero   <= (acc_nxt == '0);
                    valid  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed checks of the execute-stage ALU: reset, single-cycle ops, mult, busy stall, flush, reset abort.
module tb_alu_exec_unit;
    localparam int WIDTH = 32;

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n;

    alu_exec_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = op;
        bus.src1_i    = a;
        bus.src2_i    = b;
    endtask

    task automatic idle_req();
        bus.valid_i = 1'b0;
    endtask

    task automatic out_chk(input string tag, input logic v, input logic [31:0] r, input logic z);
        chk({tag, "_valid"},  32'(bus.valid_o),  32'(v));
        chk({tag, "_result"}, bus.result_o,      r);
        chk({tag, "_zero"},   32'(bus.zero_o),   32'(z));
    endtask

    // Counts cycles with ready_o low; leaves us at the negedge where ready_o returns.
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!bus.ready_o && cycles < 100) begin
            chk("mul_no_valid", 32'(bus.valid_o), 32'd0);
            cycles++;
            tick();
        end
    endtask

    initial begin
        rst_i = 1'b0;
        bus.valid_i = 1'b0; bus.ALUCtrl_i = '0; bus.src1_i = '0; bus.src2_i = '0; bus.flush_i = 1'b0;
        @(negedge clk_i);
        tick(); tick();
        out_chk("rst", 1'b0, 32'd0, 1'b1);
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_busy",  32'(bus.busy_o),  32'd0);
        rst_i = 1'b1;
        tick();
        out_chk("rst_rel", 1'b0, 32'd0, 1'b1);

        req(4'd2, 32'd5, 32'd7);                tick(); out_chk("add", 1'b1, 32'd12, 1'b0);
        req(4'd6, 32'd9, 32'd9);                tick(); out_chk("sub", 1'b1, 32'd0, 1'b1);
        req(4'd7, 32'hFFFF_FFFF, 32'd1);        tick(); out_chk("slt", 1'b1, 32'd1, 1'b0);
        req(4'd0, 32'h0000_F0F0, 32'h0000_FF00); tick(); out_chk("and", 1'b1, 32'h0000_F000, 1'b0);
        req(4'd1, 32'h0000_00A0, 32'h0000_0005); tick(); out_chk("or", 1'b1, 32'h0000_00A5, 1'b0);
        req(4'd5, 32'd3, 32'd4);                tick(); out_chk("undef", 1'b1, 32'd0, 1'b1);
        chk("undef_ready", 32'(bus.ready_o), 32'd1);
        idle_req();                             tick(); out_chk("idle", 1'b0, 32'd0, 1'b1);

        req(4'd2, 32'd1, 32'd2); bus.flush_i = 1'b1; tick();
        out_chk("flush_idle", 1'b0, 32'd0, 1'b1);
        bus.flush_i = 1'b0; idle_req();

        req(4'd3, 32'hFFFF_FFFD, 32'd7); tick(); idle_req();
        chk("mul_busy", 32'(bus.busy_o), 32'd1);
        wait_ready(n);
        chk("mul_cycles", 32'(n), 32'd32);
        out_chk("mul_neg", 1'b1, 32'hFFFF_FFEB, 1'b0);

        req(4'd3, 32'h0001_0000, 32'h0001_0000); tick(); idle_req();
        wait_ready(n);
        chk("mul2_cycles", 32'(n), 32'd32);
        out_chk("mul_ovf", 1'b1, 32'd0, 1'b1);

        req(4'd3, 32'd3, 32'd4); tick();
        req(4'd2, 32'd1, 32'd1);
        wait_ready(n);
        chk("mul3_cycles", 32'(n), 32'd32);
        out_chk("mul_first", 1'b1, 32'd12, 1'b0);
        tick(); idle_req();
        out_chk("add_after", 1'b1, 32'd2, 1'b0);

        req(4'd3, 32'd5, 32'd6); tick(); idle_req();
        repeat (10) tick();
        chk("flush_pre_busy", 32'(bus.busy_o), 32'd1);
        bus.flush_i = 1'b1; tick(); bus.flush_i = 1'b0;
        chk("flush_ready", 32'(bus.ready_o), 32'd1);
        out_chk("flush_mul", 1'b0, 32'd2, 1'b0);
        tick();
        out_chk("flush_after", 1'b0, 32'd2, 1'b0);

        req(4'd3, 32'd5, 32'd6); tick(); idle_req();
        repeat (20) tick();
        rst_i = 1'b0; tick(); rst_i = 1'b1;
        out_chk("rst_mul", 1'b0, 32'd0, 1'b1);
        chk("rst_mul_ready", 32'(bus.ready_o), 32'd1);
        req(4'd2, 32'd2, 32'd3); tick(); idle_req();
        out_chk("add_post_rst", 1'b1, 32'd5, 1'b0);
        tick();
        chk("add_post_rst_pulse", 32'(bus.valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
